// File: rtl/distance_renderer.sv
// distance_renderer: walks a snapshot of the distance-meter BCD digits and
// issues one sprite-draw command per valid digit over a valid/ready handshake,
// then pulses done. Frames with paint low draw nothing but still pulse done.
module distance_renderer #(
    parameter int unsigned MAX_DISTANCE_UNITS = 5,
    parameter int unsigned X_ORIGIN           = 500,
    parameter int unsigned Y_ORIGIN           = 5,
    parameter int unsigned DIGIT_STRIDE       = 11
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                frame_start,
    input  logic [MAX_DISTANCE_UNITS-1:0][3:0]  digits,
    input  logic                                paint,
    output logic                                cmd_valid,
    input  logic                                cmd_ready,
    output logic [10:0]                         cmd_x,
    output logic [9:0]                          cmd_y,
    output logic [3:0]                          cmd_sprite,
    output logic                                cmd_last,
    output logic                                done,
    output logic                                overrun
);

    localparam int unsigned IDX_W    = (MAX_DISTANCE_UNITS > 1) ? $clog2(MAX_DISTANCE_UNITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_DISTANCE_UNITS - 1);
    localparam logic [9:0]       Y_PIX    = 10'(Y_ORIGIN);
    localparam logic [3:0]       MAX_BCD  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                               r_state;
    logic [MAX_DISTANCE_UNITS-1:0][3:0]   r_snap;
    logic [IDX_W-1:0]                     r_i;
    logic                                 r_cmd_valid;
    logic [10:0]                          r_cmd_x;
    logic [9:0]                           r_cmd_y;
    logic [3:0]                           r_cmd_sprite;
    logic                                 r_cmd_last;
    logic                                 r_done;
    logic                                 r_overrun;

    logic [IDX_W-1:0]                     w_last_in;
    logic [IDX_W-1:0]                     w_last_snap;
    logic [IDX_W-1:0]                     w_i_nxt;
    logic [3:0]                           w_d_nxt;
    logic                                 w_adv;

    // Index of the rightmost digit that is a legal BCD value (0 if none).
    function automatic logic [IDX_W-1:0] f_last_valid(
        input logic [MAX_DISTANCE_UNITS-1:0][3:0] d
    );
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < int'(MAX_DISTANCE_UNITS); k++) begin
            if (d[k] <= MAX_BCD) begin
                idx = IDX_W'(k);
            end
        end
        return idx;
    endfunction

    // Screen x of a digit slot, wrapped to the 11-bit pixel bus.
    function automatic logic [10:0] f_x(input logic [IDX_W-1:0] idx);
        return 11'(X_ORIGIN + 32'(idx) * DIGIT_STRIDE);
    endfunction

    // Helpers for the incoming frame and the next slot of the current frame.
    assign w_last_in   = f_last_valid(digits);
    assign w_last_snap = f_last_valid(r_snap);
    assign w_i_nxt     = (r_i == LAST_IDX) ? '0 : r_i + IDX_W'(1);
    assign w_d_nxt     = r_snap[w_i_nxt];
    assign w_adv       = !r_cmd_valid || cmd_ready;

    // Frame sequencer with registered command, done and overrun outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_snap       <= '0;
            r_i          <= '0;
            r_cmd_valid  <= 1'b0;
            r_cmd_x      <= '0;
            r_cmd_y      <= '0;
            r_cmd_sprite <= '0;
            r_cmd_last   <= 1'b0;
            r_done       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_overrun <= frame_start && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_snap <= digits;
                        r_i    <= '0;
                        if (paint) begin
                            r_state      <= S_EMIT;
                            r_cmd_valid  <= (digits[0] <= MAX_BCD);
                            r_cmd_x      <= f_x('0);
                            r_cmd_y      <= Y_PIX;
                            r_cmd_sprite <= digits[0];
                            r_cmd_last   <= (digits[0] <= MAX_BCD) && (w_last_in == '0);
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    // Advance on acceptance, or unconditionally past an invalid digit.
                    if (w_adv) begin
                        if (r_i == LAST_IDX) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_cmd_valid <= 1'b0;
                            r_cmd_last  <= 1'b0;
                        end else begin
                            r_i          <= w_i_nxt;
                            r_cmd_valid  <= (w_d_nxt <= MAX_BCD);
                            r_cmd_x      <= f_x(w_i_nxt);
                            r_cmd_sprite <= w_d_nxt;
                            r_cmd_last   <= (w_d_nxt <= MAX_BCD) && (w_i_nxt == w_last_snap);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_valid  = r_cmd_valid;
    assign cmd_x      = r_cmd_x;
    assign cmd_y      = r_cmd_y;
    assign cmd_sprite = r_cmd_sprite;
    assign cmd_last   = r_cmd_last;
    assign done       = r_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_distance_renderer.sv
// Bench for distance_renderer: stimulus pushes expected draw commands and the
// done event into a scoreboard; an independent monitor checks DUT output.
module tb_distance_renderer;

    localparam int MAX = 5;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  frame_start = 1'b0;
    logic [MAX-1:0][3:0]   digits = '0;
    logic                  paint = 1'b0;
    logic                  cmd_ready = 1'b0;
    logic                  cmd_valid;
    logic [10:0]           cmd_x;
    logic [9:0]            cmd_y;
    logic [3:0]            cmd_sprite;
    logic                  cmd_last;
    logic                  done;
    logic                  overrun;

    distance_renderer dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .digits      (digits),
        .paint       (paint),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_sprite  (cmd_sprite),
        .cmd_last    (cmd_last),
        .done        (done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // mode: 0 = done at absolute cycle, 1 = done one cycle after last accept,
    //       2 = done only ordered after the last accept
    typedef struct {
        bit          is_done;
        logic [10:0] x;
        logic [3:0]  sp;
        bit          last;
        int          mode;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   errors = 0;
    int   checks = 0;
    int   ovr_seen = 0;
    int   exp_ovr = 0;
    int   last_acc = 0;
    int   ready_mode = 0;
    bit   alt_ph = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [MAX-1:0][3:0] mk(input logic [3:0] a, input logic [3:0] b,
                                                input logic [3:0] c, input logic [3:0] d,
                                                input logic [3:0] e);
        logic [MAX-1:0][3:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e;
        return r;
    endfunction

    // Reference model: one command per legal BCD digit, left to right, then done.
    task automatic expect_frame(input logic [MAX-1:0][3:0] d, input bit p, input int n0,
                                input int mode);
        exp_t e;
        int   lastv = -1;
        for (int k = 0; k < MAX; k++) if (d[k] <= 4'd9) lastv = k;
        if (p) begin
            for (int k = 0; k < MAX; k++) begin
                if (d[k] <= 4'd9) begin
                    e.is_done = 1'b0;
                    e.x       = 11'(500 + 11 * k);
                    e.sp      = d[k];
                    e.last    = (k == lastv);
                    e.mode    = 0;
                    e.cyc     = 0;
                    sb.push_back(e);
                end
            end
        end
        e.is_done = 1'b1;
        e.x       = '0;
        e.sp      = '0;
        e.last    = 1'b0;
        e.cyc     = n0 + (p ? MAX : 0);
        if (mode == 0 || !p)      e.mode = 0;
        else if (d[MAX-1] <= 4'd9) e.mode = 1;
        else                       e.mode = 2;
        sb.push_back(e);
    endtask

    // Monitor: compares presented commands and done pulses against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (done) begin
                if (sb.size() == 0 || !sb[0].is_done) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no done (cyc %0d)", cyc);
                end else begin
                    me = sb.pop_front();
                    if (me.mode == 0)      chk("done_cycle", cyc, me.cyc);
                    else if (me.mode == 1) chk("done_after_last_accept", cyc, last_acc + 1);
                    else                   chk("done_order", 32'(cyc > last_acc), 1);
                end
            end
            if (cmd_valid) begin
                if (sb.size() == 0 || sb[0].is_done) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got cmd_valid=1 x=%0d expected no command (cyc %0d)",
                             cmd_x, cyc);
                end else begin
                    chk("cmd_x", 32'(cmd_x), 32'(sb[0].x));
                    chk("cmd_y", 32'(cmd_y), 32'd5);
                    chk("cmd_sprite", 32'(cmd_sprite), 32'(sb[0].sp));
                    chk("cmd_last", 32'(cmd_last), 32'(sb[0].last));
                    if (cmd_ready) begin
                        void'(sb.pop_front());
                        last_acc = cyc;
                    end
                end
            end
            if (overrun) ovr_seen++;
        end
    end

    // Ready driver: 0 always high, 1 alternating from 0, 2 random, 3 held by stimulus.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0: cmd_ready = 1'b1;
            1: begin
                cmd_ready = alt_ph;
                alt_ph    = ~alt_ph;
            end
            2: cmd_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending items expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
        chk("overrun_count", ovr_seen, exp_ovr);
    endtask

    task automatic run_frame(input logic [MAX-1:0][3:0] d, input bit p, input int mode,
                             input bit do_ovr);
        int n0;
        ready_mode = mode;
        @(posedge clk);
        #1;
        digits      = d;
        paint       = p;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        alt_ph      = 1'b0;
        n0          = cyc;
        expect_frame(d, p, n0, mode);
        // Scramble inputs mid-frame; the snapshot must shield the frame.
        digits = mk(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        paint  = ~p;
        if (do_ovr) begin
            @(posedge clk);
            #1;
            frame_start = 1'b1;
            @(posedge clk);
            #1;
            frame_start = 1'b0;
            exp_ovr++;
        end
        wait_drain();
    endtask

    task automatic reset_mid_frame();
        int n0;
        ready_mode = 3;
        cmd_ready  = 1'b1;
        @(posedge clk);
        #1;
        digits      = mk(4'd0, 4'd0, 4'd1, 4'd2, 4'd3);
        paint       = 1'b1;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        n0          = cyc;
        expect_frame(digits, 1'b1, n0, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        cmd_ready = 1'b0;
        #2;
        chk("pending_valid", 32'(cmd_valid), 32'd1);
        chk("pending_x", 32'(cmd_x), 32'd522);
        rst = 1'b0;
        #1;
        chk("rst_cmd_valid", 32'(cmd_valid), 0);
        chk("rst_cmd_x", 32'(cmd_x), 0);
        chk("rst_cmd_y", 32'(cmd_y), 0);
        chk("rst_cmd_sprite", 32'(cmd_sprite), 0);
        chk("rst_cmd_last", 32'(cmd_last), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_overrun", 32'(overrun), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b1;
        ready_mode = 0;
    endtask

    initial begin
        logic [MAX-1:0][3:0] d;
        bit                  p;
        #3;
        chk("reset_cmd_valid", 32'(cmd_valid), 0);
        chk("reset_cmd_x", 32'(cmd_x), 0);
        chk("reset_cmd_y", 32'(cmd_y), 0);
        chk("reset_cmd_sprite", 32'(cmd_sprite), 0);
        chk("reset_cmd_last", 32'(cmd_last), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_overrun", 32'(overrun), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        run_frame(mk(4'd0, 4'd0, 4'd1, 4'd2, 4'd3), 1'b1, 0, 1'b0);
        run_frame(mk(4'd0, 4'd0, 4'd1, 4'd2, 4'd3), 1'b1, 1, 1'b0);
        run_frame(mk(4'd7, 4'd8, 4'd9, 4'd1, 4'd2), 1'b0, 0, 1'b0);
        run_frame(mk(4'hA, 4'd0, 4'd0, 4'd5, 4'hF), 1'b1, 0, 1'b0);
        run_frame(mk(4'hB, 4'hC, 4'hD, 4'hE, 4'hF), 1'b1, 0, 1'b0);
        run_frame(mk(4'd9, 4'd4, 4'd6, 4'd2, 4'd8), 1'b1, 0, 1'b1);
        reset_mid_frame();
        run_frame(mk(4'd0, 4'd0, 4'd1, 4'd2, 4'd3), 1'b1, 0, 1'b0);

        for (int f = 0; f < 30; f++) begin
            for (int k = 0; k < MAX; k++) begin
                if ($urandom_range(0, 3) == 0) d[k] = 4'($urandom_range(10, 15));
                else                           d[k] = 4'($urandom_range(0, 9));
            end
            p = ($urandom_range(0, 3) != 0);
            run_frame(d, p, int'($urandom_range(0, 2)), p && ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish by 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
